// File: rtl/ife_alloc_pkg.sv
// Shared types and helpers for the core allocator and its per-core trackers.
package ife_alloc_pkg;

  // Per-core availability state.
  typedef enum logic [1:0] {
    BUSY     = 2'd0,
    SETTLE   = 2'd1,
    IDLE     = 2'd2,
    RESERVED = 2'd3
  } trk_state_e;

  // Index width for n cores, never narrower than one bit.
  function automatic int calc_core_w(input int n);
    int w;
    w = 1;
    for (int i = 1; i < 31; i++) begin
      if ((1 << i) < n) w = i + 1;
    end
    return w;
  endfunction

endpackage

// File: rtl/ife_core_tracker.sv
// One core's availability tracker: idle hysteresis plus reservation timeout.
module ife_core_tracker
  import ife_alloc_pkg::*;
#(
  parameter int IDLE_CYCLES  = 2,
  parameter int RESV_TIMEOUT = 16
) (
  input  logic clk,
  input  logic rst_n,
  input  logic busy,
  input  logic reserve,
  output logic is_idle,
  output logic timeout_pulse
);

  localparam int CNT_W  = $clog2(IDLE_CYCLES + 1);
  localparam int TCNT_W = $clog2(RESV_TIMEOUT + 1);

  trk_state_e        state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [TCNT_W-1:0] tcnt_q, tcnt_d;
  logic              tout_q, tout_d;
  logic [CNT_W-1:0]  cnt_inc;

  assign cnt_inc = cnt_q + CNT_W'(1);

  // State register; reset forces every core to re-prove quietness.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= SETTLE;
      cnt_q   <= '0;
      tcnt_q  <= '0;
      tout_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      tcnt_q  <= tcnt_d;
      tout_q  <= tout_d;
    end
  end

  // Next-state logic; busy always overrides reservation and timeout.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    tcnt_d  = tcnt_q;
    tout_d  = 1'b0;
    case (state_q)
      BUSY: begin
        if (!busy) begin
          if (IDLE_CYCLES == 1) begin
            state_d = IDLE;
          end else begin
            state_d = SETTLE;
            cnt_d   = CNT_W'(1);
          end
        end
      end
      SETTLE: begin
        if (busy) begin
          state_d = BUSY;
        end else begin
          cnt_d = cnt_inc;
          if (cnt_inc == CNT_W'(IDLE_CYCLES)) state_d = IDLE;
        end
      end
      IDLE: begin
        if (busy) begin
          state_d = BUSY;
        end else if (reserve) begin
          state_d = RESERVED;
          tcnt_d  = '0;
        end
      end
      RESERVED: begin
        if (busy) begin
          state_d = BUSY;
        end else if (tcnt_q == TCNT_W'(RESV_TIMEOUT - 1)) begin
          state_d = IDLE;
          tout_d  = 1'b1;
        end else begin
          tcnt_d = tcnt_q + TCNT_W'(1);
        end
      end
      default: state_d = SETTLE;
    endcase
  end

  // Outputs derived from registered state.
  always_comb begin
    is_idle       = (state_q == IDLE);
    timeout_pulse = tout_q;
  end

endmodule

// File: rtl/ife_core_allocator.sv
// Core availability monitor and round-robin allocator for the dispatch stage.
module ife_core_allocator
  import ife_alloc_pkg::*;
#(
  parameter int NUM_CORES    = 4,
  parameter int IDLE_CYCLES  = 2,
  parameter int RESV_TIMEOUT = 16,
  localparam int CORE_W      = calc_core_w(NUM_CORES),
  localparam int CNT_W       = $clog2(NUM_CORES + 1)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [NUM_CORES-1:0] core_busy,
  input  logic [NUM_CORES-1:0] core_enable,
  input  logic                 alloc_req,
  output logic                 alloc_gnt,
  output logic [CORE_W-1:0]    alloc_core_id,
  output logic [NUM_CORES-1:0] core_idle_mask,
  output logic [CNT_W-1:0]     idle_count,
  output logic                 all_busy,
  output logic [NUM_CORES-1:0] resv_timeout
);

  logic [NUM_CORES-1:0] is_idle;
  logic [NUM_CORES-1:0] reserve;
  logic [NUM_CORES-1:0] eligible;

  logic              alloc_gnt_q, alloc_gnt_d;
  logic [CORE_W-1:0] core_id_q, core_id_d;
  logic [CORE_W-1:0] rr_ptr_q, rr_ptr_d;

  logic              found;
  logic [CORE_W-1:0] winner;
  logic [CORE_W-1:0] winner_next;
  logic              grant_fire;
  logic [CNT_W-1:0]  pop;

  genvar gi;
  generate
    for (gi = 0; gi < NUM_CORES; gi++) begin : g_trk
      assign reserve[gi] = grant_fire && (winner == CORE_W'(gi));
      ife_core_tracker #(
        .IDLE_CYCLES  (IDLE_CYCLES),
        .RESV_TIMEOUT (RESV_TIMEOUT)
      ) u_trk (
        .clk           (clk),
        .rst_n         (rst_n),
        .busy          (core_busy[gi]),
        .reserve       (reserve[gi]),
        .is_idle       (is_idle[gi]),
        .timeout_pulse (resv_timeout[gi])
      );
    end
  endgenerate

  assign eligible = is_idle & core_enable;

  // Find the first eligible core at or above the round-robin pointer, wrapping.
  always_comb begin
    int idx;
    found  = 1'b0;
    winner = '0;
    idx    = 0;
    for (int off = 0; off < NUM_CORES; off++) begin
      idx = int'(rr_ptr_q) + off;
      if (idx >= NUM_CORES) idx = idx - NUM_CORES;
      if (!found && eligible[idx]) begin
        found  = 1'b1;
        winner = CORE_W'(idx);
      end
    end
  end

  // Grant decision; a grant in flight blocks the next request for one cycle.
  always_comb begin
    grant_fire  = alloc_req && !alloc_gnt_q && found;
    winner_next = (int'(winner) == NUM_CORES - 1) ? '0 : winner + CORE_W'(1);
    alloc_gnt_d = grant_fire;
    core_id_d   = grant_fire ? winner      : core_id_q;
    rr_ptr_d    = grant_fire ? winner_next : rr_ptr_q;
  end

  // Grant and pointer registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      alloc_gnt_q <= 1'b0;
      core_id_q   <= '0;
      rr_ptr_q    <= '0;
    end else begin
      alloc_gnt_q <= alloc_gnt_d;
      core_id_q   <= core_id_d;
      rr_ptr_q    <= rr_ptr_d;
    end
  end

  // Popcount of the qualified idle mask.
  always_comb begin
    pop = '0;
    for (int i = 0; i < NUM_CORES; i++) begin
      pop = pop + CNT_W'(eligible[i]);
    end
  end

  assign alloc_gnt      = alloc_gnt_q;
  assign alloc_core_id  = core_id_q;
  assign core_idle_mask = eligible;
  assign idle_count     = pop;
  assign all_busy       = (eligible == '0);

endmodule
